crossing_scheduler: RTL and testbench

//  Two-approach intersection scheduler. Latches crossing requests from two requesters (A, B).

---
 rtl/crossing_scheduler.sv | 96 +++++++++
 tb/tb_crossing_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/crossing_scheduler.sv
// crossing_scheduler: two-approach intersection scheduler with latched requests and timed green/yellow/all-red phases
module crossing_scheduler #(
    parameter int CNT_W       = 32,
    parameter int T_MIN_GREEN = 100_000_000,
    parameter int T_YELLOW    = 50_000_000,
    parameter int T_ALLRED    = 25_000_000
) (
    input  logic       i_w_clk,
    input  logic       i_w_reset,
    input  logic       i_w_req_a,
    input  logic       i_w_req_b,
    output logic [7:0] o_r_out,
    output logic       o_r_grant_a,
    output logic       o_r_grant_b,
    output logic [2:0] o_r_phase
);
    typedef enum logic [2:0] {
        INIT   = 3'd0,
        A_GRN  = 3'd1,
        A_YEL  = 3'd2,
        RED_AB = 3'd3,
        B_GRN  = 3'd4,
        B_YEL  = 3'd5,
        RED_BA = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] L_GRN = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_YEL = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_RED = CNT_W'(T_ALLRED - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx, limit;
    logic             pend_a, pend_b, pend_a_nx, pend_b_nx;
    logic [7:0]       out_nx;

    // next phase and the saturation limit of the phase we are in; a green only yields to a pending rival
    always_comb begin
        state_nx = state;
        limit    = L_RED;
        case (state)
            INIT:    if (timer >= L_RED) state_nx = A_GRN;
            A_GRN: begin
                limit = L_GRN;
                if (timer >= L_GRN && pend_b) state_nx = A_YEL;
            end
            A_YEL: begin
                limit = L_YEL;
                if (timer >= L_YEL) state_nx = RED_AB;
            end
            RED_AB:  if (timer >= L_RED) state_nx = B_GRN;
            B_GRN: begin
                limit = L_GRN;
                if (timer >= L_GRN && pend_a) state_nx = B_YEL;
            end
            B_YEL: begin
                limit = L_YEL;
                if (timer >= L_YEL) state_nx = RED_BA;
            end
            RED_BA:  if (timer >= L_RED) state_nx = A_GRN;
            default: state_nx = INIT;
        endcase
    end

    // timer, request latches and the LED word that the new state implies
    always_comb begin
        timer_nx  = (state_nx != state) ? '0 : (timer >= limit ? timer : timer + 1'b1);
        pend_a_nx = (state_nx == A_GRN) ? 1'b0 : (pend_a | (i_w_req_a && state != A_GRN));
        pend_b_nx = (state_nx == B_GRN) ? 1'b0 : (pend_b | (i_w_req_b && state != B_GRN));
        out_nx    = {!(state_nx == A_GRN || state_nx == A_YEL), state_nx == A_YEL, state_nx == A_GRN,
                     !(state_nx == B_GRN || state_nx == B_YEL), state_nx == B_YEL, state_nx == B_GRN,
                     pend_a_nx, pend_b_nx};
    end

    // state register with outputs registered on the same edge
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state       <= INIT;
            timer       <= '0;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            o_r_out     <= 8'b1001_0000;
            o_r_grant_a <= 1'b0;
            o_r_grant_b <= 1'b0;
            o_r_phase   <= 3'd0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            pend_a      <= pend_a_nx;
            pend_b      <= pend_b_nx;
            o_r_out     <= out_nx;
            o_r_grant_a <= state_nx == A_GRN;
            o_r_grant_b <= state_nx == B_GRN;
            o_r_phase   <= state_nx;
        end
    end
endmodule

// File: tb/tb_crossing_scheduler.sv
// tb_crossing_scheduler: directed and random stimulus against a phase-duration reference model
module tb_crossing_scheduler;
    localparam int MIN = 4;
    localparam int YEL = 2;
    localparam int RED = 3;

    logic       clk = 0;
    logic       rst = 1;
    logic       req_a = 0;
    logic       req_b = 0;
    logic [7:0] out;
    logic       grant_a, grant_b;
    logic [2:0] phase;

    int n_assert = 0;
    int n_fail   = 0;

    int m_phase = 0;
    int m_age   = 0;
    bit m_pa    = 0;
    bit m_pb    = 0;

    crossing_scheduler #(.CNT_W(32), .T_MIN_GREEN(MIN), .T_YELLOW(YEL), .T_ALLRED(RED)) dut (
        .i_w_clk(clk),
        .i_w_reset(rst),
        .i_w_req_a(req_a),
        .i_w_req_b(req_b),
        .o_r_out(out),
        .o_r_grant_a(grant_a),
        .o_r_grant_b(grant_b),
        .o_r_phase(phase)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int phase_len(input int p);
        return (p == 2 || p == 5) ? YEL : (p == 1 || p == 4) ? MIN : RED;
    endfunction

    function automatic void model_step(input bit r, input bit ra, input bit rb);
        bit leave;
        int np;
        if (r) begin
            m_phase = 0; m_age = 0; m_pa = 0; m_pb = 0;
            return;
        end
        leave = (m_age + 1 >= phase_len(m_phase)) &&
                !(m_phase == 1 && !m_pb) && !(m_phase == 4 && !m_pa);
        np = leave ? (m_phase == 6 ? 1 : m_phase + 1) : m_phase;
        m_pa = m_pa | (ra && m_phase != 1);
        m_pb = m_pb | (rb && m_phase != 4);
        if (leave && np == 1) m_pa = 0;
        if (leave && np == 4) m_pb = 0;
        m_age = leave ? 0 : m_age + 1;
        m_phase = np;
    endfunction

    function automatic logic [7:0] model_out();
        bit ag = m_phase == 1, ay = m_phase == 2, bg = m_phase == 4, by = m_phase == 5;
        return {!(ag || ay), ay, ag, !(bg || by), by, bg, m_pa, m_pb};
    endfunction

    task automatic step(input bit r, input bit ra, input bit rb);
        rst = r; req_a = ra; req_b = rb;
        @(posedge clk);
        model_step(r, ra, rb);
        #1;
        check("phase", 32'(phase), 32'(m_phase));
        check("leds", 32'(out), 32'(model_out()));
        check("grant_a", 32'(grant_a), 32'(m_phase == 1));
        check("grant_b", 32'(grant_b), 32'(m_phase == 4));
        check("grant_excl", 32'(grant_a & grant_b), 32'd0);
    endtask

    initial begin
        bit hit;
        step(1, 0, 0);
        step(1, 0, 0);
        check("reset_leds", 32'(out), 32'h90);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("init_to_agrn_phase", 32'(phase), 32'd1);
        check("init_to_agrn_leds", 32'(out), 32'h30);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("own_green_req_ignored", 32'(out[1]), 32'd0);
        step(0, 0, 1);
        check("pend_b_latched", 32'(out[0]), 32'd1);
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        check("bgrn_after_yield", 32'(phase), 32'd4);
        for (int i = 0; i < 60; i++) step(0, 1, 1);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(0, 1, 1);
            hit = phase == 3'd5;
        end
        check("reach_b_yel", 32'(hit), 32'd1);
        step(1, 1, 1);
        check("midphase_reset_phase", 32'(phase), 32'd0);
        check("midphase_reset_leds", 32'(out), 32'h90);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        step(0, 0, 1);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(0, 0, 0);
            hit = phase == 3'd2;
        end
        check("reach_a_yel", 32'(hit), 32'd1);
        step(0, 1, 0);
        check("pend_a_in_yellow", 32'(out[1]), 32'd1);
        for (int i = 0; i < 30; i++) step(0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
